traffic_light_monitor: RTL

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/tl_pkg.sv | 37 +++
 rtl/tl_road_checker.sv | 91 +++++++++
 rtl/traffic_light_monitor.sv | 88 ++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared traffic-light types: light encoding, fault codes, default dwell times.
// Used by the light monitor and by the traffic-light controller.
package tl_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b10,
    GREEN  = 2'b11
  } light_t;

  localparam logic [1:0] LIGHT_ILLEGAL = 2'b01;

  typedef enum logic [2:0] {
    FLT_NONE     = 3'd0,
    FLT_ILLEGAL  = 3'd1,
    FLT_CONFLICT = 3'd2,
    FLT_BAD_SEQ  = 3'd3,
    FLT_TIMING   = 3'd4
  } fault_t;

  typedef enum logic {
    ROAD_INIT  = 1'b0,
    ROAD_TRACK = 1'b1
  } road_state_t;

  localparam int GT_DEFAULT = 45;
  localparam int YT_DEFAULT = 15;

  localparam logic [6:0] DWELL_MAX = 7'd127;

  function automatic logic legal_step(input light_t from, input light_t to);
    return ((from == GREEN)  && (to == YELLOW)) ||
           ((from == YELLOW) && (to == RED))    ||
           ((from == RED)    && (to == GREEN));
  endfunction

endpackage

// File: rtl/tl_road_checker.sv
// Per-road checker: tracks the last legal sample and its dwell, and flags
// illegal codes, bad light sequences and GREEN/YELLOW dwell violations.
//
// state      | meaning
// ROAD_INIT  | no sample since reset; next legal sample seeds prev/dwell
// ROAD_TRACK | prev/dwell valid; sequence and timing checks active
module tl_road_checker
  import tl_pkg::*;
#(
  parameter int   GT        = GT_DEFAULT,
  parameter int   YT        = YT_DEFAULT,
  parameter logic CYCLE_REF = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] road,
  output logic       illegal,
  output logic       bad_seq,
  output logic       timing,
  output logic       cycle_hit
);

  road_state_t state_q, state_d;
  light_t      prev_q;
  logic [6:0]  dwell_q;
  logic        first_int_q;

  logic   is_illegal;
  logic   changed;
  light_t sample;

  assign is_illegal = (road == LIGHT_ILLEGAL);
  assign sample     = light_t'(road);
  assign changed    = (sample != prev_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ROAD_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ROAD_INIT:  if (!is_illegal) state_d = ROAD_TRACK;
      ROAD_TRACK: state_d = ROAD_TRACK;
      default:    state_d = ROAD_INIT;
    endcase
  end

  // Illegal samples leave prev/dwell untouched so the next legal sample is
  // judged against the last legal one.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q      <= RED;
      dwell_q     <= 7'd0;
      first_int_q <= 1'b0;
    end else if (!is_illegal) begin
      prev_q <= sample;
      if (state_q == ROAD_INIT) begin
        dwell_q     <= 7'd1;
        first_int_q <= 1'b1;
      end else if (changed) begin
        dwell_q     <= 7'd1;
        first_int_q <= 1'b0;
      end else if (dwell_q != DWELL_MAX) begin
        dwell_q <= dwell_q + 7'd1;
      end
    end
  end

  always_comb begin
    illegal   = is_illegal;
    bad_seq   = 1'b0;
    timing    = 1'b0;
    cycle_hit = 1'b0;
    if ((state_q == ROAD_TRACK) && !is_illegal) begin
      if (changed) begin
        bad_seq   = !legal_step(prev_q, sample);
        cycle_hit = CYCLE_REF && (prev_q == RED) && (sample == GREEN);
        if (!first_int_q)
          timing = ((prev_q == GREEN)  && (int'(dwell_q) < GT)) ||
                   ((prev_q == YELLOW) && (int'(dwell_q) < YT));
      end else if (!first_int_q) begin
        // dwell equals the limit exactly once per interval: overstay fires once
        timing = ((prev_q == GREEN)  && (int'(dwell_q) == GT)) ||
                 ((prev_q == YELLOW) && (int'(dwell_q) == YT));
      end
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Two-road traffic light monitor: per-road checkers plus cross-road conflict,
// fault prioritisation, sticky/first-fault capture and cycle counting.
module traffic_light_monitor
  import tl_pkg::*;
#(
  parameter int GT = GT_DEFAULT,
  parameter int YT = YT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  roadA,
  input  logic [1:0]  roadB,
  input  logic        clr_fault,
  output logic        fault_pulse,
  output logic        fault_sticky,
  output logic [2:0]  first_fault,
  output logic [7:0]  fault_cnt,
  output logic        cycle_done,
  output logic [15:0] cycle_cnt
);

  logic a_illegal, a_bad_seq, a_timing, a_cycle;
  logic b_illegal, b_bad_seq, b_timing, b_cycle;
  logic conflict;
  logic fault_now;
  logic cycle_hit;
  fault_t fault_code;

  tl_road_checker #(.GT(GT), .YT(YT), .CYCLE_REF(1'b1)) u_road_a (
    .clk       (clk),
    .rst       (rst),
    .road      (roadA),
    .illegal   (a_illegal),
    .bad_seq   (a_bad_seq),
    .timing    (a_timing),
    .cycle_hit (a_cycle)
  );

  tl_road_checker #(.GT(GT), .YT(YT), .CYCLE_REF(1'b0)) u_road_b (
    .clk       (clk),
    .rst       (rst),
    .road      (roadB),
    .illegal   (b_illegal),
    .bad_seq   (b_bad_seq),
    .timing    (b_timing),
    .cycle_hit (b_cycle)
  );

  assign conflict  = (roadA != RED) && (roadB != RED);
  assign cycle_hit = a_cycle | b_cycle;

  always_comb begin
    fault_code = FLT_NONE;
    if (a_illegal || b_illegal)      fault_code = FLT_ILLEGAL;
    else if (conflict)               fault_code = FLT_CONFLICT;
    else if (a_bad_seq || b_bad_seq) fault_code = FLT_BAD_SEQ;
    else if (a_timing || b_timing)   fault_code = FLT_TIMING;
  end

  assign fault_now = (fault_code != FLT_NONE);

  // A fault in the same cycle as clr_fault restarts capture from that fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_pulse  <= 1'b0;
      fault_sticky <= 1'b0;
      first_fault  <= 3'd0;
      fault_cnt    <= 8'd0;
      cycle_done   <= 1'b0;
      cycle_cnt    <= 16'd0;
    end else begin
      fault_pulse <= fault_now;
      cycle_done  <= cycle_hit;
      if (cycle_hit) cycle_cnt <= cycle_cnt + 16'd1;
      if (fault_now) begin
        fault_sticky <= 1'b1;
        if (clr_fault || (first_fault == 3'd0)) first_fault <= fault_code;
        if (clr_fault)                 fault_cnt <= 8'd1;
        else if (fault_cnt != 8'hFF)   fault_cnt <= fault_cnt + 8'd1;
      end else if (clr_fault) begin
        fault_sticky <= 1'b0;
        first_fault  <= 3'd0;
        fault_cnt    <= 8'd0;
      end
    end
  end

endmodule
